// File: rtl/iob_pbus_merge_arbiter.sv
// Round-robin merge of N IOb managers onto one subordinate, one transaction in flight.
// Grant is registered (1-cycle arbitration); request/response paths are combinational through the grant.
module iob_pbus_merge_arbiter #(
    parameter int N      = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N-1:0]          m_iob_valid_i,
    input  logic [N*ADDR_W-1:0]   m_iob_addr_i,
    input  logic [N*DATA_W-1:0]   m_iob_wdata_i,
    input  logic [N*DATA_W/8-1:0] m_iob_wstrb_i,
    output logic [N-1:0]          m_iob_ready_o,
    output logic [N-1:0]          m_iob_rvalid_o,
    output logic [N*DATA_W-1:0]   m_iob_rdata_o,
    output logic                  s_iob_valid_o,
    output logic [ADDR_W-1:0]     s_iob_addr_o,
    output logic [DATA_W-1:0]     s_iob_wdata_o,
    output logic [DATA_W/8-1:0]   s_iob_wstrb_o,
    input  logic                  s_iob_ready_i,
    input  logic                  s_iob_rvalid_i,
    input  logic [DATA_W-1:0]     s_iob_rdata_i,
    output logic [N-1:0]          grant_o,
    output logic                  busy_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W+1:0] N_EXT = (PTR_W + 2)'(N);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [PTR_W-1:0]  ptr, pick;
    logic [N-1:0]      pick_oh;
    logic              pick_vld;
    logic [PTR_W:0]    start, pick_off;
    logic [PTR_W+1:0]  pick_sum;
    logic [2*N-1:0]    req_dbl;
    logic [N-1:0]      req_rot;

    logic              g_vld;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [STRB_W-1:0] g_wstrb;

    // Rotate the request vector so bit 0 is the manager after ptr, then take the lowest set bit.
    assign start    = {1'b0, ptr} + (PTR_W + 1)'(1);
    assign req_dbl  = {m_iob_valid_i, m_iob_valid_i} >> start;
    assign req_rot  = req_dbl[N-1:0];
    assign pick_vld = |m_iob_valid_i;

    always_comb begin
        pick_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) pick_off = (PTR_W + 1)'(j);
        end
        pick_sum = {1'b0, start} + {1'b0, pick_off};
        if (pick_sum >= N_EXT) pick_sum = pick_sum - N_EXT;
        pick = pick_sum[PTR_W-1:0];
        for (int k = 0; k < N; k++) pick_oh[k] = (pick == PTR_W'(k));
    end

    // ptr always holds the index of the current (or last) granted manager.
    always_comb begin
        g_vld   = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int k = 0; k < N; k++) begin
            if (ptr == PTR_W'(k)) begin
                g_vld   = m_iob_valid_i[k];
                g_addr  = m_iob_addr_i[k*ADDR_W +: ADDR_W];
                g_wdata = m_iob_wdata_i[k*DATA_W +: DATA_W];
                g_wstrb = m_iob_wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = GRANT;
            GRANT: begin
                if (!g_vld)              state_nxt = IDLE;
                else if (s_iob_ready_i)  state_nxt = (|g_wstrb) ? IDLE : WAIT_R;
            end
            WAIT_R:  if (s_iob_rvalid_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ptr     <= PTR_W'(N - 1);
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != IDLE);
            if (state == IDLE && pick_vld) begin
                ptr     <= pick;
                grant_o <= pick_oh;
            end else if (state_nxt == IDLE) begin
                grant_o <= '0;
            end
        end
    end

    always_comb begin
        s_iob_valid_o = (state == GRANT) && g_vld;
        s_iob_addr_o  = s_iob_valid_o ? g_addr  : '0;
        s_iob_wdata_o = s_iob_valid_o ? g_wdata : '0;
        s_iob_wstrb_o = s_iob_valid_o ? g_wstrb : '0;
        m_iob_rdata_o = '0;
        for (int k = 0; k < N; k++) begin
            m_iob_ready_o[k]  = (state == GRANT)  && (ptr == PTR_W'(k)) && s_iob_ready_i;
            m_iob_rvalid_o[k] = (state == WAIT_R) && (ptr == PTR_W'(k)) && s_iob_rvalid_i;
            if (state == WAIT_R && ptr == PTR_W'(k)) m_iob_rdata_o[k*DATA_W +: DATA_W] = s_iob_rdata_i;
        end
    end

endmodule

// File: tb/tb_iob_pbus_merge_arbiter.sv
// Bench for iob_pbus_merge_arbiter: manager/subordinate models with a transfer and read-response scoreboard.
module tb_iob_pbus_merge_arbiter;
    localparam int N      = 4;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int SW     = DATA_W / 8;
    localparam logic [DATA_W-1:0] JUNK = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]        m_valid, m_ready, m_rvalid;
    logic [N*ADDR_W-1:0] m_addr;
    logic [N*DATA_W-1:0] m_wdata, m_rdata;
    logic [N*SW-1:0]     m_wstrb;
    logic                s_valid, s_ready, s_rvalid, busy;
    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wdata, s_rdata;
    logic [SW-1:0]       s_wstrb;
    logic [N-1:0]        grant;

    iob_pbus_merge_arbiter #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_iob_valid_i(m_valid), .m_iob_addr_i(m_addr), .m_iob_wdata_i(m_wdata),
        .m_iob_wstrb_i(m_wstrb), .m_iob_ready_o(m_ready), .m_iob_rvalid_o(m_rvalid),
        .m_iob_rdata_o(m_rdata),
        .s_iob_valid_o(s_valid), .s_iob_addr_o(s_addr), .s_iob_wdata_o(s_wdata),
        .s_iob_wstrb_o(s_wstrb), .s_iob_ready_i(s_ready), .s_iob_rvalid_i(s_rvalid),
        .s_iob_rdata_i(s_rdata), .grant_o(grant), .busy_o(busy)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SW-1:0]     wstrb;
        int                hold;
    } req_t;
    typedef struct {
        int                mgr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SW-1:0]     wstrb;
    } exp_s_t;
    typedef struct {
        int                mgr;
        logic [DATA_W-1:0] rdata;
    } exp_r_t;

    req_t   mq[N][$];
    exp_s_t exp_s[$];
    exp_r_t exp_r[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int hold_c[N], age[N], load_cyc[N], ready_cnt[N], rv_cnt[N];
    int busy_cnt, svld_cnt, s_acc_cnt, last_lat;
    logic [N-1:0] gnt_log[$];
    int           gnt_cyc[$];
    logic [N-1:0] prev_grant = '0;

    logic              sub_ready_mode = 1'b1;
    int                sub_lat = 1;
    int                sub_cnt = 0;
    logic [DATA_W-1:0] sub_data = '0;
    logic              fixed_en = 1'b0;
    logic [DATA_W-1:0] fixed_rdata = '0;

    logic [N-1:0]      m_acc_s;
    logic              s_acc_s, s_read_s;
    logic [ADDR_W-1:0] s_addr_s;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic monitor();
        m_acc_s = m_valid & m_ready;
        s_acc_s = s_valid & s_ready;
        s_read_s = (s_wstrb == '0);
        s_addr_s = s_addr;
        chk("ready_only_granted", 64'(m_ready & ~grant), 64'(0));
        chk("rvalid_only_granted", 64'(m_rvalid & ~grant), 64'(0));
        if (!s_valid) begin
            chk("s_addr_idle_zero", 64'(s_addr), 64'(0));
            chk("s_data_idle_zero", 64'({s_wdata, s_wstrb}), 64'(0));
        end
        for (int k = 0; k < N; k++) begin
            if (!grant[k]) chk("rdata_nongranted_zero", 64'(m_rdata[k*DATA_W +: DATA_W]), 64'(0));
            ready_cnt[k] += int'(m_ready[k]);
            rv_cnt[k]    += int'(m_rvalid[k]);
        end
        busy_cnt += int'(busy);
        svld_cnt += int'(s_valid);
        if (grant != '0 && prev_grant == '0) begin
            gnt_log.push_back(grant);
            gnt_cyc.push_back(cyc);
        end
        prev_grant = grant;
        if (s_acc_s) begin
            s_acc_cnt++;
            if (exp_s.size() == 0) chk("s_xfer_expected", 64'(exp_s.size()), 64'(1));
            else begin
                exp_s_t e = exp_s.pop_front();
                chk("s_xfer_grant", 64'(grant), 64'(1) << e.mgr);
                chk("s_xfer_addr", 64'(s_addr), 64'(e.addr));
                chk("s_xfer_wdata", 64'(s_wdata), 64'(e.wdata));
                chk("s_xfer_wstrb", 64'(s_wstrb), 64'(e.wstrb));
                last_lat = cyc - load_cyc[e.mgr];
            end
        end
        if (m_rvalid != '0) begin
            if (exp_r.size() == 0) chk("rvalid_expected", 64'(exp_r.size()), 64'(1));
            else begin
                exp_r_t e = exp_r.pop_front();
                chk("rvalid_mgr", 64'(m_rvalid), 64'(1) << e.mgr);
                chk("rvalid_rdata", 64'(m_rdata[e.mgr*DATA_W +: DATA_W]), 64'(e.rdata));
            end
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (m_acc_s[k] || (m_valid[k] && hold_c[k] > 0 && age[k] >= hold_c[k])) m_valid[k] = 1'b0;
            if (!m_valid[k] && mq[k].size() > 0) begin
                req_t r = mq[k].pop_front();
                m_addr[k*ADDR_W +: ADDR_W] = r.addr;
                m_wdata[k*DATA_W +: DATA_W] = r.wdata;
                m_wstrb[k*SW +: SW] = r.wstrb;
                hold_c[k] = r.hold;
                age[k] = 0;
                load_cyc[k] = cyc;
                m_valid[k] = 1'b1;
            end
            if (m_valid[k]) age[k]++;
        end
        s_rvalid = 1'b0;
        s_rdata = JUNK;
        if (s_acc_s && s_read_s) begin
            sub_cnt = sub_lat;
            sub_data = fixed_en ? fixed_rdata : rd_fn(s_addr_s);
        end
        if (sub_cnt > 0) begin
            sub_cnt--;
            if (sub_cnt == 0) begin
                s_rvalid = 1'b1;
                s_rdata = sub_data;
            end
        end
        s_ready = sub_ready_mode;
    endtask

    initial begin
        m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = 1'b1; s_rvalid = 1'b0; s_rdata = JUNK;
        for (int k = 0; k < N; k++) begin
            hold_c[k] = 0; age[k] = 0; load_cyc[k] = 0; ready_cnt[k] = 0; rv_cnt[k] = 0;
        end
        busy_cnt = 0; svld_cnt = 0; s_acc_cnt = 0; last_lat = 0;
        forever begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            cyc++;
            #1;
            drive();
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic add_req(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [SW-1:0] s, input int hold);
        req_t r;
        r.addr = a; r.wdata = d; r.wstrb = s; r.hold = hold;
        mq[k].push_back(r);
    endtask

    task automatic exp_xfer(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [SW-1:0] s, input logic rsp, input logic [DATA_W-1:0] rd);
        exp_s_t e;
        exp_r_t r;
        e.mgr = k; e.addr = a; e.wdata = d; e.wstrb = s;
        exp_s.push_back(e);
        if (rsp) begin
            r.mgr = k; r.rdata = rd;
            exp_r.push_back(r);
        end
    endtask

    function automatic logic all_idle();
        logic q_empty = 1'b1;
        for (int k = 0; k < N; k++) if (mq[k].size() != 0) q_empty = 1'b0;
        return q_empty && m_valid == '0 && sub_cnt == 0 && !s_rvalid && !busy
               && exp_s.size() == 0 && exp_r.size() == 0;
    endfunction

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        step();
        while (n < maxc && !all_idle()) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 64'(all_idle()), 64'(1));
    endtask

    task automatic clr_stats();
        for (int k = 0; k < N; k++) begin
            ready_cnt[k] = 0;
            rv_cnt[k] = 0;
        end
        busy_cnt = 0; svld_cnt = 0; s_acc_cnt = 0;
        gnt_log.delete();
        gnt_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_order(input string tag, input int cnt, input int modn, input int base);
        chk({tag, "_ngrants"}, 64'(gnt_log.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < gnt_log.size(); i++)
            chk({tag, "_grant_order"}, 64'(gnt_log[i]), 64'(1) << ((base + i) % modn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_s_valid", 64'(s_valid), 64'(0));
        chk("rst_s_addr", 64'(s_addr), 64'(0));
        chk("rst_m_ready", 64'(m_ready), 64'(0));
        chk("rst_m_rvalid", 64'(m_rvalid), 64'(0));
        chk("rst_m_rdata", 64'(m_rdata[63:0]), 64'(0));
        rst = 1'b0;

        // Single write from manager 2, zero-wait subordinate.
        clr_stats();
        add_req(2, 30'h0000_0100, 32'hA5A5_A5A5, 4'hF, 0);
        exp_xfer(2, 30'h0000_0100, 32'hA5A5_A5A5, 4'hF, 1'b0, '0);
        drain("t1", 20);
        chk("t1_s_valid_cycles", 64'(svld_cnt), 64'(1));
        chk("t1_ready2_pulses", 64'(ready_cnt[2]), 64'(1));
        chk("t1_req_to_xfer_latency", 64'(last_lat), 64'(1));
        chk_order("t1", 1, N, 2);

        // Read from manager 0 with 3-cycle subordinate latency.
        clr_stats();
        sub_lat = 3; fixed_en = 1'b1; fixed_rdata = 32'h1234_5678;
        add_req(0, 30'h0000_0040, '0, '0, 0);
        exp_xfer(0, 30'h0000_0040, '0, '0, 1'b1, 32'h1234_5678);
        drain("t2", 30);
        chk("t2_busy_cycles", 64'(busy_cnt), 64'(4));
        chk("t2_rvalid0_pulses", 64'(rv_cnt[0]), 64'(1));
        chk("t2_rvalid_other", 64'(rv_cnt[1] + rv_cnt[2] + rv_cnt[3]), 64'(0));
        fixed_en = 1'b0;

        // Managers 0 and 1 write continuously.
        do_reset();
        clr_stats();
        sub_lat = 1;
        for (int i = 0; i < 4; i++) begin
            add_req(0, ADDR_W'(32'h200 + i * 4), 32'h1000_0000 + i, 4'hF, 0);
            add_req(1, ADDR_W'(32'h300 + i * 4), 32'h2000_0000 + i, 4'h3, 0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_xfer(0, ADDR_W'(32'h200 + i * 4), 32'h1000_0000 + i, 4'hF, 1'b0, '0);
            exp_xfer(1, ADDR_W'(32'h300 + i * 4), 32'h2000_0000 + i, 4'h3, 1'b0, '0);
        end
        drain("t3", 60);
        chk_order("t3", 8, 2, 0);
        if (gnt_cyc.size() == 8) chk("t3_b2b_write_rate", 64'(gnt_cyc[7] - gnt_cyc[0]), 64'(14));

        // All four managers read continuously.
        do_reset();
        clr_stats();
        sub_lat = 2;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                logic [ADDR_W-1:0] a = ADDR_W'(32'h400 + k * 16 + r * 4);
                add_req(k, a, '0, '0, 0);
                exp_xfer(k, a, '0, '0, 1'b1, rd_fn(a));
            end
        end
        drain("t4", 100);
        chk_order("t4", 8, N, 0);
        for (int k = 0; k < N; k++) chk("t4_rvalid_per_mgr", 64'(rv_cnt[k]), 64'(2));

        // Reset while waiting for read data; the late rvalid must be dropped.
        clr_stats();
        sub_lat = 6;
        add_req(2, 30'h0000_0500, '0, '0, 0);
        exp_xfer(2, 30'h0000_0500, '0, '0, 1'b0, '0);
        begin
            int n = 0;
            while (s_acc_cnt == 0 && n < 50) begin
                step();
                n++;
            end
            chk("t5_read_accepted", 64'(s_acc_cnt), 64'(1));
        end
        step();
        chk("t5_busy_in_wait", 64'(busy), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy_after_rst", 64'(busy), 64'(0));
        chk("t5_grant_after_rst", 64'(grant), 64'(0));
        drain("t5a", 30);
        chk("t5_late_rvalid_dropped", 64'(rv_cnt[0] + rv_cnt[1] + rv_cnt[2] + rv_cnt[3]), 64'(0));
        clr_stats();
        sub_lat = 1;
        add_req(3, 30'h0000_0600, 32'h3333_3333, 4'hF, 0);
        add_req(0, 30'h0000_0604, 32'h0000_0000, 4'h1, 0);
        exp_xfer(0, 30'h0000_0604, 32'h0000_0000, 4'h1, 1'b0, '0);
        exp_xfer(3, 30'h0000_0600, 32'h3333_3333, 4'hF, 1'b0, '0);
        drain("t5b", 20);
        chk("t5_post_rst_ngrants", 64'(gnt_log.size()), 64'(2));
        if (gnt_log.size() == 2) begin
            chk("t5_post_rst_first", 64'(gnt_log[0]), 64'(4'b0001));
            chk("t5_post_rst_second", 64'(gnt_log[1]), 64'(4'b1000));
        end

        // Granted manager drops valid while the subordinate stalls.
        do_reset();
        clr_stats();
        sub_ready_mode = 1'b0;
        add_req(0, 30'h0000_0700, '0, '0, 2);
        add_req(1, 30'h0000_0704, 32'hCAFE_F00D, 4'hC, 0);
        exp_xfer(1, 30'h0000_0704, 32'hCAFE_F00D, 4'hC, 1'b0, '0);
        repeat (10) step();
        chk("t6_no_xfer_while_stalled", 64'(s_acc_cnt), 64'(0));
        chk("t6_ngrants", 64'(gnt_log.size()), 64'(2));
        if (gnt_log.size() == 2) begin
            chk("t6_first_grant", 64'(gnt_log[0]), 64'(4'b0001));
            chk("t6_regrant", 64'(gnt_log[1]), 64'(4'b0010));
            chk("t6_regrant_gap", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'(3));
        end
        sub_ready_mode = 1'b1;
        drain("t6", 20);
        chk("t6_single_xfer", 64'(s_acc_cnt), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
